// File: rtl/scan_pattern_detector.sv
// Serial PATTERN detector that counts overlapping matches, with optional mux-D scan over NCHAIN balanced chains.
// Scan muxes exist only when SCAN_CHAIN_EN is defined. Without it, scan_mode and scan_in are ignored and scan_out is 0.
module scan_pattern_detector #(
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011,
    parameter int              CW      = 4,
    parameter int              NCHAIN  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic              in_valid,
    input  logic              count_clr,
    output logic              match,
    output logic              match_q,
    output logic [CW-1:0]     count,
    input  logic              scan_mode,
    input  logic [NCHAIN-1:0] scan_in,
    output logic [NCHAIN-1:0] scan_out
);
    localparam int FW       = $clog2(PLEN);
    localparam int F        = PLEN - 1 + FW + 1 + CW;
    localparam int L        = (F + NCHAIN - 1) / NCHAIN;
    localparam int FILL_LSB = PLEN - 1;
    localparam int MQ_BIT   = PLEN - 1 + FW;
    localparam int CNT_LSB  = MQ_BIT + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(PLEN - 1);

    // All state lives in one vector laid out in scan order, so V[0] = hist[0].
    logic [F-1:0]    v_q;
    logic [F-1:0]    v_d;
    logic [F-1:0]    func_v;
    logic [PLEN-2:0] hist_q;
    logic [PLEN-2:0] hist_d;
    logic [FW-1:0]   fill_q;
    logic [FW-1:0]   fill_d;
    logic            mq_q;
    logic            mq_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [PLEN-1:0] window;
    logic            scan_active;
    logic            match_c;

    assign hist_q  = v_q[PLEN-2:0];
    assign fill_q  = v_q[FILL_LSB +: FW];
    assign mq_q    = v_q[MQ_BIT];
    assign count_q = v_q[CNT_LSB +: CW];

    always_comb begin
        window  = {hist_q, a};
        match_c = ~scan_active & in_valid & (fill_q == FILL_MAX) & (window == PATTERN);
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (in_valid) begin
            hist_d = window[PLEN-2:0];
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
        mq_d    = match_c;
        count_d = count_q;
        // A clear that coincides with a match leaves that match counted.
        if (count_clr) begin
            count_d = match_c ? CW'(1) : '0;
        end else if (match_c && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
        func_v = {count_d, mq_d, fill_d, hist_d};
    end

`ifdef SCAN_CHAIN_EN
    logic [F-1:0] shift_v;

    assign scan_active = scan_mode;

    genvar gi;
    generate
        for (gi = 0; gi < F; gi++) begin : g_shift
            if ((gi % L) == 0) begin : g_head
                assign shift_v[gi] = scan_in[gi / L];
            end else begin : g_body
                assign shift_v[gi] = v_q[gi - 1];
            end
        end
        // With many chains the trailing ones may own no flops. Their outputs are tied low.
        for (gi = 0; gi < NCHAIN; gi++) begin : g_out
            localparam int HEAD = gi * L;
            localparam int TAIL = (((gi + 1) * L) < F) ? ((gi + 1) * L - 1) : (F - 1);
            if (HEAD < F) begin : g_used
                assign scan_out[gi] = v_q[TAIL];
            end else begin : g_empty
                assign scan_out[gi] = 1'b0;
            end
        end
    endgenerate

    assign v_d = scan_mode ? shift_v : func_v;
`else
    logic unused_scan;

    assign unused_scan = ^{scan_mode, scan_in};
    assign scan_active = 1'b0;
    assign v_d         = func_v;
    assign scan_out    = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign match   = match_c;
    assign match_q = mq_q;
    assign count   = count_q;

endmodule

// File: tb/tb_scan_pattern_detector.sv
// Scoreboard bench: two detectors (patterns 1011 and 0011) share one randomized stimulus stream.
// A rule-level model pushes the expected outputs, and a negedge monitor pops and compares them.
module tb_scan_pattern_detector;
    localparam int PLEN = 4, CW = 4, NCHAIN = 2, FW = 2, F = 10, L = 5;
`ifdef SCAN_CHAIN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, a, in_valid, count_clr, scan_mode;
    logic [1:0] scan_in;
    logic match0, mq0, match1, mq1;
    logic [3:0] cnt0, cnt1;
    logic [1:0] so0, so1;

    always #5 clk = ~clk;

    scan_pattern_detector #(.PLEN(4), .PATTERN(4'b1011), .CW(4), .NCHAIN(2)) u_dut (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .count_clr(count_clr),
        .match(match0), .match_q(mq0), .count(cnt0),
        .scan_mode(scan_mode), .scan_in(scan_in), .scan_out(so0));

    scan_pattern_detector #(.PLEN(4), .PATTERN(4'b0011), .CW(4), .NCHAIN(2)) u_dut2 (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .count_clr(count_clr),
        .match(match1), .match_q(mq1), .count(cnt1),
        .scan_mode(scan_mode), .scan_in(scan_in), .scan_out(so1));

    typedef struct packed {
        logic m0; logic q0; logic [3:0] c0; logic [1:0] s0;
        logic m1; logic q1; logic [3:0] c1; logic [1:0] s1;
        logic [7:0] ph;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0, failures = 0, ph = 0, txn = 0;

    // Model state: recent bits (index 0 newest), fill level, registered match and count.
    bit   m_hist[2][PLEN-1];
    int   m_fill[2];
    bit   m_mq[2];
    int   m_cnt[2];
    logic [3:0] pats[2];
    bit   vb[F];

    function automatic bit model_match(int k);
        bit ok;
        if (SCAN_BUILD && scan_mode) return 1'b0;
        if (!in_valid) return 1'b0;
        if (m_fill[k] < PLEN - 1) return 1'b0;
        ok = (a == pats[k][0]);
        for (int i = 1; i < PLEN; i++) begin
            if (m_hist[k][i-1] != pats[k][i]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic void to_v(int k);
        for (int i = 0; i < PLEN - 1; i++) vb[i] = m_hist[k][i];
        for (int i = 0; i < FW; i++) vb[PLEN-1+i] = bit'((m_fill[k] >> i) & 1);
        vb[PLEN-1+FW] = m_mq[k];
        for (int i = 0; i < CW; i++) vb[PLEN+FW+i] = bit'((m_cnt[k] >> i) & 1);
    endfunction

    function automatic void from_v(int k);
        for (int i = 0; i < PLEN - 1; i++) m_hist[k][i] = vb[i];
        m_fill[k] = 0;
        for (int i = 0; i < FW; i++) m_fill[k] += int'(vb[PLEN-1+i]) << i;
        m_mq[k] = vb[PLEN-1+FW];
        m_cnt[k] = 0;
        for (int i = 0; i < CW; i++) m_cnt[k] += int'(vb[PLEN+FW+i]) << i;
    endfunction

    function automatic logic [1:0] exp_so(int k);
        logic [1:0] r;
        r = 2'b00;
        to_v(k);
        for (int c = 0; c < NCHAIN; c++) begin
            int tail;
            tail = ((c + 1) * L < F) ? (c + 1) * L - 1 : F - 1;
            if (SCAN_BUILD) r[c] = vb[tail];
        end
        return r;
    endfunction

    function automatic void step(int k);
        bit m;
        bit nv[F];
        if (reset) begin
            for (int i = 0; i < PLEN - 1; i++) m_hist[k][i] = 1'b0;
            m_fill[k] = 0; m_mq[k] = 1'b0; m_cnt[k] = 0;
        end else if (SCAN_BUILD && scan_mode) begin
            to_v(k);
            for (int j = 0; j < F; j++) nv[j] = ((j % L) == 0) ? scan_in[j / L] : vb[j-1];
            vb = nv;
            from_v(k);
        end else begin
            m = model_match(k);
            if (in_valid) begin
                for (int i = PLEN - 2; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
                m_hist[k][0] = a;
                if (m_fill[k] < PLEN - 1) m_fill[k]++;
            end
            m_mq[k] = m;
            if (count_clr) m_cnt[k] = m ? 1 : 0;
            else if (m && m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s ph=%0d t=%0t got=%0d expected=%0d", name, ph, $time, got, exp_v);
        end
    endtask

    task automatic drive(input bit rst, input bit av, input bit iv, input bit clr,
                         input bit sm, input logic [1:0] si);
        exp_t e;
        reset = rst; a = av; in_valid = iv; count_clr = clr; scan_mode = sm; scan_in = si;
        e.m0 = model_match(0); e.q0 = m_mq[0]; e.c0 = 4'(m_cnt[0]); e.s0 = exp_so(0);
        e.m1 = model_match(1); e.q1 = m_mq[1]; e.c1 = 4'(m_cnt[1]); e.s1 = exp_so(1);
        e.ph = 8'(ph);
        sb_q.push_back(e);
        @(posedge clk);
        step(0);
        step(1);
        #1;
    endtask

    task automatic feed(input bit av);
        drive(1'b0, av, 1'b1, 1'b0, 1'b0, 2'($urandom));
    endtask

    task automatic do_reset();
        drive(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 2'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d ph=%0d match=%b/%b match_q=%b/%b count=%0d/%0d scan_out=%b/%b",
                         txn, e.ph, match0, match1, mq0, mq1, cnt0, cnt1, so0, so1);
                chk("match0", int'(match0), int'(e.m0));
                chk("match_q0", int'(mq0), int'(e.q0));
                chk("count0", int'(cnt0), int'(e.c0));
                chk("scan_out0", int'(so0), int'(e.s0));
                chk("match1", int'(match1), int'(e.m1));
                chk("match_q1", int'(mq1), int'(e.q1));
                chk("count1", int'(cnt1), int'(e.c1));
                chk("scan_out1", int'(so1), int'(e.s1));
            end
        end
    end

    initial begin : stim
        logic [4:0] load_bits;
        pats[0] = 4'b1011;
        pats[1] = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < PLEN - 1; i++) m_hist[k][i] = 1'b0;
            m_fill[k] = 0; m_mq[k] = 1'b0; m_cnt[k] = 0;
        end
        reset = 1'b1; a = 1'b0; in_valid = 1'b0; count_clr = 1'b0; scan_mode = 1'b0; scan_in = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        ph = 1;  // reset with random inputs
        do_reset();
        do_reset();
        chk("reset_count", int'(cnt0), 0);

        ph = 2;  // overlapping stream
        foreach (pats[i]) begin end
        feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
        chk("stream_count", int'(cnt0), 2);
        feed(0);

        ph = 3;  // fill gating with pattern 0011
        do_reset();
        feed(0); feed(1); feed(1);
        chk("fill_nomatch_count", int'(cnt1), 0);
        do_reset();
        feed(0); feed(0); feed(1); feed(1);
        chk("fill_match_count", int'(cnt1), 1);

        ph = 4;  // in_valid gaps
        do_reset();
        feed(1);
        drive(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 2'b00);
        feed(0);
        drive(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 2'b00);
        feed(1);
        drive(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 2'b00);
        feed(1);
        drive(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 2'b00);
        chk("gap_count", int'(cnt0), 1);

        ph = 5;  // saturation and clear
        do_reset();
        feed(1); feed(0); feed(1); feed(1);
        for (int i = 0; i < 19; i++) begin
            feed(0); feed(1); feed(1);
        end
        chk("sat_count", int'(cnt0), 15);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("clr_count", int'(cnt0), 0);
        feed(1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("clr_match_count", int'(cnt0), 1);

        ph = 6;  // scan load, capture, unload, reset while shifting
        do_reset();
        load_bits = 5'b01101;  // applied LSB first: 1,0,1,1,0
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1, {1'($urandom), load_bits[i]});
        chk("scan_load_tail", int'(so0[0]), SCAN_BUILD ? 1 : 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'($urandom));
        for (int i = 0; i < 10; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 2'($urandom));
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 2'b11);
        drive(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 2'b11);
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 2'b00);

        ph = 7;  // randomized traffic
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), 2'($urandom));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
